// File: rtl/frame_scan_pkg.sv
// ============================================================================
// frame_scan_pkg : shared state encoding and constants for the frame scanner
// Rev 1.0
// ============================================================================
`default_nettype none

package frame_scan_pkg;

   localparam int MIN_DIM        = 3;
   localparam int DEFAULT_ADDR_W = 32;
   localparam int DEFAULT_DIM_W  = 16;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD0   = 3'd1,
      S_RD1   = 3'd2,
      S_RD2   = 3'd3,
      S_SHIFT = 3'd4,
      S_WR    = 3'd5,
      S_ADV   = 3'd6,
      S_FIN   = 3'd7
   } state_t;

endpackage

`default_nettype wire

// File: rtl/scan_addr_gen.sv
// ============================================================================
// scan_addr_gen : row/column counters and running row-base address registers
// Rev 1.0
// ============================================================================
`default_nettype none

module scan_addr_gen
   import frame_scan_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int DIM_W  = DEFAULT_DIM_W
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              i_launch,
   input  logic              i_adv,
   input  logic [DIM_W-1:0]  i_width,
   input  logic [DIM_W-1:0]  i_height,
   input  logic [ADDR_W-1:0] i_raddr,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [1:0]        i_k,
   output logic [ADDR_W-1:0] o_rd_addr,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic              o_col_ge2,
   output logic              o_frame_end
);

   logic [DIM_W-1:0]  r_width;
   logic [DIM_W-1:0]  r_height;
   logic [DIM_W-1:0]  r_row;
   logic [DIM_W-1:0]  r_col;
   logic [ADDR_W-1:0] r_rbase;
   logic [ADDR_W-1:0] r_wbase;

   logic [ADDR_W-1:0] w_width_a;
   logic [ADDR_W-1:0] w_col_a;
   logic [ADDR_W-1:0] w_kofs;
   logic [DIM_W-1:0]  w_row_inc;
   logic              w_last_col;

   assign w_width_a = ADDR_W'(r_width);
   assign w_col_a   = ADDR_W'(r_col);

   // Row offset inside the 3-pixel column: 0, W or 2W, built without a multiplier.
   always_comb begin
      w_kofs = '0;
      case (i_k)
         2'd1:    w_kofs = w_width_a;
         2'd2:    w_kofs = w_width_a << 1;
         default: w_kofs = '0;
      endcase
   end

   assign o_rd_addr   = r_rbase + w_kofs + w_col_a;
   assign o_wr_addr   = r_wbase + w_col_a - ADDR_W'(2);
   assign w_last_col  = (r_col == (r_width - DIM_W'(1)));
   assign w_row_inc   = r_row + DIM_W'(1);
   assign o_col_ge2   = (r_col >= DIM_W'(2));
   assign o_frame_end = w_last_col && (w_row_inc == (r_height - DIM_W'(2)));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_width  <= '0;
         r_height <= '0;
         r_row    <= '0;
         r_col    <= '0;
         r_rbase  <= '0;
         r_wbase  <= '0;
      end else if (i_launch) begin
         r_width  <= i_width;
         r_height <= i_height;
         r_row    <= '0;
         r_col    <= '0;
         r_rbase  <= i_raddr;
         r_wbase  <= i_waddr;
      end else if (i_adv) begin
         if (w_last_col) begin
            r_col   <= '0;
            r_row   <= w_row_inc;
            r_rbase <= r_rbase + w_width_a;
            r_wbase <= r_wbase + w_width_a - ADDR_W'(2);
         end else begin
            r_col   <= r_col + DIM_W'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/frame_scan_controller.sv
// ============================================================================
// frame_scan_controller : sequences 3x3-window reads and result writes per frame
// Rev 1.0
// ============================================================================
`default_nettype none

module frame_scan_controller
   import frame_scan_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int DIM_W  = DEFAULT_DIM_W
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic [DIM_W-1:0]  cfg_width,
   input  logic [DIM_W-1:0]  cfg_height,
   input  logic [ADDR_W-1:0] cfg_raddr,
   input  logic [ADDR_W-1:0] cfg_waddr,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              cfg_err,
   output logic              bus_req,
   output logic              bus_write,
   output logic [ADDR_W-1:0] bus_addr,
   input  logic              bus_ack,
   output logic              pix_load,
   output logic [1:0]        pix_row,
   output logic              col_shift,
   output logic              res_take
);

   state_t            r_state;
   logic              w_legal;
   logic              w_launch;
   logic              w_rd_state;
   logic [1:0]        w_k;
   logic [ADDR_W-1:0] w_rd_addr;
   logic [ADDR_W-1:0] w_wr_addr;
   logic              w_col_ge2;
   logic              w_frame_end;

   assign w_legal    = (cfg_width >= DIM_W'(MIN_DIM)) && (cfg_height >= DIM_W'(MIN_DIM));
   assign w_launch   = (r_state == S_IDLE) && start && w_legal;
   assign w_rd_state = (r_state == S_RD0) || (r_state == S_RD1) || (r_state == S_RD2);

   always_comb begin
      w_k = 2'd0;
      case (r_state)
         S_RD1:   w_k = 2'd1;
         S_RD2:   w_k = 2'd2;
         default: w_k = 2'd0;
      endcase
   end

   scan_addr_gen #(
      .ADDR_W (ADDR_W),
      .DIM_W  (DIM_W)
   ) u_addr_gen (
      .clk         (clk),
      .n_rst       (n_rst),
      .i_launch    (w_launch),
      .i_adv       (r_state == S_ADV),
      .i_width     (cfg_width),
      .i_height    (cfg_height),
      .i_raddr     (cfg_raddr),
      .i_waddr     (cfg_waddr),
      .i_k         (w_k),
      .o_rd_addr   (w_rd_addr),
      .o_wr_addr   (w_wr_addr),
      .o_col_ge2   (w_col_ge2),
      .o_frame_end (w_frame_end)
   );

   // Address only changes at state/counter edges, so it is stable for a whole request.
   assign bus_addr  = w_rd_state ? w_rd_addr : ((r_state == S_WR) ? w_wr_addr : '0);
   assign pix_load  = w_rd_state && bus_ack;
   assign pix_row   = w_k;
   assign col_shift = (r_state == S_SHIFT);
   assign res_take  = (r_state == S_WR) && bus_ack;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state   <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         cfg_err   <= 1'b0;
         bus_req   <= 1'b0;
         bus_write <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (w_legal) begin
                     cfg_err   <= 1'b0;
                     busy      <= 1'b1;
                     bus_req   <= 1'b1;
                     bus_write <= 1'b0;
                     r_state   <= S_RD0;
                  end else begin
                     cfg_err   <= 1'b1;
                     r_state   <= S_FIN;
                  end
               end
            end
            S_RD0: if (bus_ack) r_state <= S_RD1;
            S_RD1: if (bus_ack) r_state <= S_RD2;
            S_RD2: begin
               if (bus_ack) begin
                  bus_req <= 1'b0;
                  r_state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (w_col_ge2) begin
                  bus_req   <= 1'b1;
                  bus_write <= 1'b1;
                  r_state   <= S_WR;
               end else begin
                  r_state   <= S_ADV;
               end
            end
            S_WR: begin
               if (bus_ack) begin
                  bus_req   <= 1'b0;
                  bus_write <= 1'b0;
                  r_state   <= S_ADV;
               end
            end
            S_ADV: begin
               if (w_frame_end) begin
                  r_state <= S_FIN;
               end else begin
                  bus_req <= 1'b1;
                  r_state <= S_RD0;
               end
            end
            S_FIN: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/frame_scan_controller.md
FRAME_SCAN_CONTROLLER -- requirements
Module: frame_scan_controller

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, the bus address width; DIM_W, default 16, the image dimension width.
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state updates on its rising edge.
- n_rst  in  1  reset, asynchronous and active-low.
- cfg_width  in  DIM_W  image width in pixels.
- cfg_height  in  DIM_W  image height in pixels.
- cfg_raddr  in  ADDR_W  pixel address of source pixel (0,0).
- cfg_waddr  in  ADDR_W  pixel address of result pixel (0,0).
- start  in  1  one-cycle pulse that launches a frame.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at frame end.
- cfg_err  out  1  sticky flag for an illegal geometry.
- bus_req  out  1  transaction request to the pipelined master.
- bus_write  out  1  1 = write, 0 = read; valid while bus_req is high.
- bus_addr  out  ADDR_W  pixel address; valid while bus_req is high.
- bus_ack  in  1  transaction completed this cycle.
- pix_load  out  1  pulse: the read data now on the master return path belongs to row pix_row.
- pix_row  out  2  row index 0..2 within the current 3-pixel column.
- col_shift  out  1  pulse: the datapath shifts its 3x3 window by one column.
- res_take  out  1  pulse: the datapath result has been written; the datapath advances.

Function
REQ-003 States SHALL be IDLE, RD0, RD1, RD2, SHIFT, WR, ADV and FIN.
REQ-004 In IDLE, a start pulse with cfg_width>=3 and cfg_height>=3 SHALL latch all cfg_* inputs, clear the counters (row=0, col=0), set busy and enter RD0; bus_req SHALL be high on the next cycle.
REQ-005 In IDLE, a start pulse with cfg_width<3 or cfg_height<3 SHALL set cfg_err, issue no bus transactions, and enter FIN.
REQ-006 In RDk (k=0..2), the controller SHALL hold bus_req=1, bus_write=0 and bus_addr = raddr_l + (row+k)*width_l + col, constant until bus_ack.
REQ-007 On bus_ack in RDk, the controller SHALL pulse pix_load with pix_row=k in the same cycle and advance to RD(k+1), or from RD2 to SHIFT.
REQ-008 SHIFT SHALL last one cycle with col_shift=1, then go to WR if col>=2, otherwise to ADV.
REQ-009 In WR, the controller SHALL hold bus_req=1, bus_write=1 and bus_addr = waddr_l + row*(width_l-2) + (col-2) until bus_ack; on ack it SHALL pulse res_take and go to ADV.
REQ-010 ADV SHALL last one cycle and update the counters as follows:
- If col < width_l-1: col += 1.
- Otherwise: col = 0 and row += 1.
- Then, if row == height_l-2, go to FIN; otherwise go to RD0.
REQ-011 FIN SHALL pulse done for one cycle, clear busy and return to IDLE.
REQ-012 Address generation SHALL be multiplier-free: running row-base registers are incremented by width_l and width_l-2 per row, and all sums wrap modulo 2^ADDR_W.
REQ-013 A start pulse while busy SHALL be ignored; the cfg_* inputs SHALL be ignored except at launch.
REQ-014 cfg_err SHALL clear only on the next legal start or on reset.
REQ-015 A bus_ack outside RDk/WR SHALL be ignored.
REQ-016 Totals per frame SHALL be exactly 3*W*(H-2) reads and (W-2)*(H-2) writes.
REQ-017 bus_req SHALL never drop before bus_ack, and bus_addr and bus_write SHALL be stable throughout the request.

Reset
REQ-018 While n_rst=0, the block SHALL be in IDLE with every output at 0 (including bus_addr) and all counters and latched registers at 0.
REQ-019 Reset asserted mid-frame SHALL abandon the frame immediately with no done pulse; the next legal start SHALL run a full frame.

Structure
REQ-020 Package frame_scan_pkg SHALL hold the state enum, the MIN_DIM=3 constant and the default ADDR_W/DIM_W values.
REQ-021 One sub-module, scan_addr_gen, SHALL contain the row/column counters and both running base registers, and SHALL present rd_addr and wr_addr to the FSM.

Verification
REQ-022 W=4, H=3, raddr=100, waddr=200, bus_ack on every request cycle -> the following response:
- Reads in order: 100,104,108, 101,105,109, 102,106,110, 103,107,111.
- Writes: 200 after the third column, 201 after the fourth.
- done exactly once; busy low afterwards.
REQ-023 W=5, H=5, bus_ack stalled 3 cycles on every request -> bus_addr held constant during each stall, 45 reads and 9 writes, and the last write address = waddr+8.
REQ-024 W=2, H=10, start -> cfg_err=1, no bus_req at any time, and done one cycle after FIN is entered; a following legal start clears cfg_err.
REQ-025 Start pulsed again mid-frame with different cfg values -> the transaction sequence and addresses are unchanged.
REQ-026 n_rst pulled low during WR -> all outputs 0 immediately and no done pulse; a restart produces the full REQ-022 sequence.
REQ-027 raddr=32'hFFFF_FFFE, W=4, H=3 -> the first column reads FFFF_FFFE, 2, 6 (wrap-around).
